spi_reg_master: RTL

SPI_REG_MASTER -- requirements
Module: spi_reg_master

---
 rtl/spi_reg_master.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_master.sv
// ---------------------------------------------------------------------------
// spi_reg_master
//   SPI mode-0 master for two-byte register transactions. A request latches
//   {rw, addr, wdata}; the block then shifts byte 0 = {rw, addr} and
//   byte 1 = wdata (write) or 0x00 (read), MSB first, with ss held low for
//   both bytes. On reads the second received byte is returned on rdata.
//
//   Frame (in clk cycles, D = CLK_DIV):
//     SETUP D | BYTE0 16D | [GAP GAP_CYCLES] | BYTE1 16D | HOLD D | RECOVER D
//   done pulses on the last RECOVER cycle: 35*D (+GAP_CYCLES) after accept.
//
//   Configuration macro: SPI_REG_MASTER_BYTE_GAP_EN
//     defined   -> GAP state of GAP_CYCLES sclk-low cycles between the bytes
//     undefined -> byte 1 follows byte 0 back-to-back (no GAP state/counter)
//
// Parameters
//   CLK_DIV     sclk half-period in clk cycles (2..255)
//   GAP_CYCLES  inter-byte idle cycles (1..256, used only with the macro)
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   start    in   one-cycle request, accepted only when idle
//   rw       in   0 = read, 1 = write (sampled with start)
//   addr     in   7-bit register address (sampled with start)
//   wdata    in   write data (sampled with start)
//   busy     out  transaction in progress
//   done     out  one-cycle completion pulse
//   rdata    out  last read data
//   sclk     out  SPI clock, idle low
//   mosi     out  SPI data out, MSB first
//   miso     in   SPI data in
//   ss       out  active-low slave select
// ---------------------------------------------------------------------------
module spi_reg_master #(
    parameter int unsigned CLK_DIV    = 25,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       ss
);

    // Elaboration-time guard on the legal parameter ranges.
    if (CLK_DIV < 2 || CLK_DIV > 255 || GAP_CYCLES < 1 || GAP_CYCLES > 256) begin : g_bad_param
        $error("spi_reg_master: CLK_DIV must be 2..255 and GAP_CYCLES 1..256");
    end

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
    localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StByte0,
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
        StGap,
`endif
        StByte1,
        StHold,
        StRecover
    } state_t;

    state_t      r_state, w_state;
    logic [7:0]  r_div, w_div;
    logic [2:0]  r_bit, w_bit;
    logic [15:0] r_tx, w_tx;
    logic [7:0]  r_rx, w_rx;
    logic        r_rw, w_rw;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic [7:0]  r_rdata, w_rdata;
    logic        r_sclk, w_sclk;
    logic        r_mosi, w_mosi;
    logic        r_ss, w_ss;
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
    logic [7:0]  r_gap, w_gap;
`endif

    logic w_div_zero;
    assign w_div_zero = (r_div == 8'd0);

    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_tx    = r_tx;
        w_rx    = r_rx;
        w_rw    = r_rw;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_rdata = r_rdata;
        w_sclk  = r_sclk;
        w_mosi  = r_mosi;
        w_ss    = r_ss;
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
        w_gap   = r_gap;
`endif
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state = StSetup;
                    w_div   = DivLast;
                    w_tx    = {rw, addr, (rw ? wdata : 8'h00)};
                    w_rw    = rw;
                    w_rx    = 8'h00;
                    w_bit   = 3'd0;
                    w_busy  = 1'b1;
                    w_ss    = 1'b0;
                    w_sclk  = 1'b0;
                    w_mosi  = rw; // byte-0 MSB presented during SETUP
                end
            end
            StSetup: begin
                if (w_div_zero) begin
                    w_state = StByte0;
                    w_div   = DivLast;
                    w_bit   = 3'd0;
                end else begin
                    w_div = r_div - 8'd1;
                end
            end
            StByte0, StByte1: begin
                if (!w_div_zero) begin
                    w_div = r_div - 8'd1;
                end else begin
                    w_div = DivLast;
                    if (!r_sclk) begin
                        // Rising edge: only byte-1 bits are kept.
                        w_sclk = 1'b1;
                        if (r_state == StByte1) begin
                            w_rx = {r_rx[6:0], miso};
                        end
                    end else begin
                        // Falling edge: present the next bit while sclk is low.
                        w_sclk = 1'b0;
                        w_mosi = r_tx[14];
                        w_tx   = {r_tx[14:0], 1'b0};
                        w_bit  = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            if (r_state == StByte1) begin
                                w_state = StHold;
                            end else begin
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
                                w_state = StGap;
                                w_gap   = GapLast;
`else
                                w_state = StByte1;
`endif
                            end
                        end
                    end
                end
            end
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
            StGap: begin
                if (r_gap == 8'd0) begin
                    w_state = StByte1;
                    w_div   = DivLast;
                end else begin
                    w_gap = r_gap - 8'd1;
                end
            end
`endif
            StHold: begin
                if (w_div_zero) begin
                    w_state = StRecover;
                    w_div   = DivLast;
                    w_ss    = 1'b1;
                end else begin
                    w_div = r_div - 8'd1;
                end
            end
            StRecover: begin
                if (w_div_zero) begin
                    w_state = StIdle;
                end else begin
                    w_div = r_div - 8'd1;
                    // Arm done/rdata so they appear together on the final cycle.
                    if (r_div == 8'd1) begin
                        w_done = 1'b1;
                        w_busy = 1'b0;
                        if (!r_rw) begin
                            w_rdata = r_rx;
                        end
                    end
                end
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_div   <= 8'd0;
            r_bit   <= 3'd0;
            r_tx    <= 16'h0000;
            r_rx    <= 8'h00;
            r_rw    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_ss    <= 1'b1;
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
            r_gap   <= 8'd0;
`endif
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_tx    <= w_tx;
            r_rx    <= w_rx;
            r_rw    <= w_rw;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_rdata <= w_rdata;
            r_sclk  <= w_sclk;
            r_mosi  <= w_mosi;
            r_ss    <= w_ss;
`ifdef SPI_REG_MASTER_BYTE_GAP_EN
            r_gap   <= w_gap;
`endif
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign rdata = r_rdata;
    assign sclk  = r_sclk;
    assign mosi  = r_mosi;
    assign ss    = r_ss;

endmodule
